// File: rtl/mar_seq_if.sv
// W-bus side of the memory address register: data, active-low strobes and registered outputs.
interface mar_seq_if #(
    parameter int unsigned AW = 16
);
    logic [AW-1:0] WBUS;
    logic          nLm;
    logic          nLb;
    logic          nInc;
    logic          nDec;
    logic [AW-1:0] address;
    logic          busy;
    logic          wrap;

    modport master (
        output WBUS, nLm, nLb, nInc, nDec,
        input  address, busy, wrap
    );

    modport slave (
        input  WBUS, nLm, nLb, nInc, nDec,
        output address, busy, wrap
    );
endinterface

// File: rtl/mar_seq.sv
// Memory address register: full load, two-step byte assembly with atomic commit,
// modular increment/decrement with a one-cycle wrap pulse.
module mar_seq #(
    parameter int unsigned    AW         = 16,
    parameter int unsigned    BW         = 8,
    parameter logic [AW-1:0]  RESET_ADDR = '0
) (
    input logic       CLK,
    input logic       CLR,
    mar_seq_if.slave  bus
);
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] LOW_HELD = 1'b1;

    // Power-up values match the reset state.
    logic [AW-1:0] address_q = RESET_ADDR;
    logic [AW-1:0] address_d;
    logic [0:0]    state_q   = IDLE;
    logic [0:0]    state_d;
    logic [BW-1:0] staging_q = '0;
    logic [BW-1:0] staging_d;
    logic          wrap_q    = 1'b0;
    logic          wrap_d;

    always_comb begin
        address_d = address_q;
        state_d   = state_q;
        staging_d = staging_q;
        wrap_d    = 1'b0;
        if (!bus.nLm) begin
            address_d = bus.WBUS;
            state_d   = IDLE;
            staging_d = '0;
        end else if (!bus.nLb) begin
            if (state_q == IDLE) begin
                staging_d = bus.WBUS[BW-1:0];
                state_d   = LOW_HELD;
            end else begin
                // High byte and staged low byte land in the same edge.
                address_d = {bus.WBUS[AW-BW-1:0], staging_q};
                state_d   = IDLE;
            end
        end else if (!bus.nInc && bus.nDec) begin
            address_d = address_q + AW'(1);
            wrap_d    = (address_q == '1);
        end else if (bus.nInc && !bus.nDec) begin
            address_d = address_q - AW'(1);
            wrap_d    = (address_q == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            address_q <= RESET_ADDR;
            state_q   <= IDLE;
            staging_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            address_q <= address_d;
            state_q   <= state_d;
            staging_q <= staging_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.address = address_q;
    assign bus.busy    = (state_q == LOW_HELD);
    assign bus.wrap    = wrap_q;
endmodule
